// File: rtl/tpg_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode encodings,
// bar colour table and pipeline latency.
package tpg_pkg;

    typedef enum logic [2:0] {
        TPG_GRID    = 3'd0,
        TPG_BARS    = 3'd1,
        TPG_RAMP    = 3'd2,
        TPG_CHECKER = 3'd3,
        TPG_SOLID   = 3'd4
    } tpg_mode_e;

    localparam int TPG_LAT = 2;

    // One bit per channel {r,g,b}; the top expands each bit to a full channel.
    function automatic logic [2:0] tpg_bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    tpg_bar_rgb = 3'b111;  // white
            3'd1:    tpg_bar_rgb = 3'b110;  // yellow
            3'd2:    tpg_bar_rgb = 3'b011;  // cyan
            3'd3:    tpg_bar_rgb = 3'b010;  // green
            3'd4:    tpg_bar_rgb = 3'b101;  // magenta
            3'd5:    tpg_bar_rgb = 3'b100;  // red
            3'd6:    tpg_bar_rgb = 3'b001;  // blue
            default: tpg_bar_rgb = 3'b000;  // black
        endcase
    endfunction

endpackage

// File: rtl/tpg_bar_counter.sv
// Divider-free colour-bar index tracker. bar_idx is registered, so it lines up
// with the stage-1 pipeline registers of the top.
module tpg_bar_counter #(
    parameter int POS_W = 12,
    parameter int BAR_W = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             display_on,
    input  logic [POS_W-1:0] hpos,
    output logic [2:0]       bar_idx
);
    import tpg_pkg::*;

    localparam int PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [PX_W-1:0] bar_px, cur_px, nxt_px;
    logic [2:0]      idx_r, cur_idx, nxt_idx;

    // State holds the position of the pixel now on hpos; hpos==0 forces a fresh line.
    always_comb begin
        cur_px  = (hpos == '0) ? '0 : bar_px;
        cur_idx = (hpos == '0) ? 3'd0 : idx_r;
        nxt_px  = cur_px;
        nxt_idx = cur_idx;
        if (display_on) begin
            if (cur_px == PX_W'(BAR_W - 1)) begin
                nxt_px  = '0;
                nxt_idx = (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
            end else begin
                nxt_px  = cur_px + PX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_px  <= '0;
            idx_r   <= 3'd0;
            bar_idx <= 3'd0;
        end else begin
            bar_px  <= nxt_px;
            idx_r   <= nxt_idx;
            bar_idx <= cur_idx;
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode VGA test-pattern source with a 2-cycle colour pipeline.
// Optional build macro TPG_SCROLL_EN scrolls GRID/RAMP/CHECKER by frame_cnt.
module test_pattern_gen #(
    parameter int COLOR_W  = 8,
    parameter int POS_W    = 12,
    parameter int H_ACTIVE = 1024,
    parameter int CHK_LOG2 = 5,
    parameter int RAMP_SH  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 display_on,
    input  logic [POS_W-1:0]     hpos,
    input  logic [POS_W-1:0]     vpos,
    input  logic [2:0]           mode_sel,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   rgb_r,
    output logic [COLOR_W-1:0]   rgb_g,
    output logic [COLOR_W-1:0]   rgb_b,
    output logic                 de_out,
    output logic [2:0]           mode_act,
    output logic [7:0]           frame_cnt
);
    import tpg_pkg::*;

    localparam int BAR_W = H_ACTIVE / 8;

    logic               fs;
    logic [2:0]         mode_cur;
    logic [POS_W-1:0]   off;
    logic [POS_W-1:0]   x_eff;
    logic [COLOR_W-1:0] ramp_nxt;
    logic [2:0]         bar_idx;

    assign fs       = display_on && (hpos == '0) && (vpos == '0);
    // The frame-start pixel already uses the newly requested mode.
    assign mode_cur = fs ? mode_sel : mode_act;

`ifdef TPG_SCROLL_EN
    logic [7:0] cnt_cur;
    assign cnt_cur = fs ? (frame_cnt + 8'd1) : frame_cnt;
    assign off     = POS_W'(cnt_cur);
`else
    assign off     = '0;
`endif

    assign x_eff    = hpos + off;
    assign ramp_nxt = COLOR_W'(x_eff >> RAMP_SH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_act  <= TPG_GRID;
            frame_cnt <= 8'd0;
        end else if (fs) begin
            mode_act  <= mode_sel;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    tpg_bar_counter #(
        .POS_W (POS_W),
        .BAR_W (BAR_W)
    ) u_bar_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .display_on (display_on),
        .hpos       (hpos),
        .bar_idx    (bar_idx)
    );

    // Stage 1 keeps only the coordinate features the colour stage needs.
    logic [2:0]           mode_s1;
    logic                 de_s1;
    logic                 grid_s1;
    logic                 x4_s1;
    logic                 y4_s1;
    logic                 chk_s1;
    logic [COLOR_W-1:0]   ramp_s1;
    logic [3*COLOR_W-1:0] solid_s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_s1  <= TPG_GRID;
            de_s1    <= 1'b0;
            grid_s1  <= 1'b0;
            x4_s1    <= 1'b0;
            y4_s1    <= 1'b0;
            chk_s1   <= 1'b0;
            ramp_s1  <= '0;
            solid_s1 <= '0;
        end else begin
            mode_s1  <= mode_cur;
            de_s1    <= display_on;
            grid_s1  <= (x_eff[2:0] == 3'd0) || (vpos[2:0] == 3'd0);
            x4_s1    <= x_eff[4];
            y4_s1    <= vpos[4];
            chk_s1   <= x_eff[CHK_LOG2] ^ vpos[CHK_LOG2];
            ramp_s1  <= ramp_nxt;
            solid_s1 <= solid_rgb;
        end
    end

    logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;
    logic [2:0]         bar_c;

    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        bar_c = tpg_bar_rgb(bar_idx);
        if (de_s1) begin
            case (mode_s1)
                TPG_GRID: begin
                    r_nxt = {COLOR_W{grid_s1}};
                    g_nxt = {COLOR_W{y4_s1}};
                    b_nxt = {COLOR_W{x4_s1}};
                end
                TPG_BARS: begin
                    r_nxt = {COLOR_W{bar_c[2]}};
                    g_nxt = {COLOR_W{bar_c[1]}};
                    b_nxt = {COLOR_W{bar_c[0]}};
                end
                TPG_RAMP: begin
                    r_nxt = ramp_s1;
                    g_nxt = ramp_s1;
                    b_nxt = ramp_s1;
                end
                TPG_CHECKER: begin
                    r_nxt = {COLOR_W{chk_s1}};
                    g_nxt = {COLOR_W{chk_s1}};
                    b_nxt = {COLOR_W{chk_s1}};
                end
                TPG_SOLID: begin
                    r_nxt = solid_s1[3*COLOR_W-1:2*COLOR_W];
                    g_nxt = solid_s1[2*COLOR_W-1:COLOR_W];
                    b_nxt = solid_s1[COLOR_W-1:0];
                end
                default: ;  // reserved modes render black
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_r  <= '0;
            rgb_g  <= '0;
            rgb_b  <= '0;
            de_out <= 1'b0;
        end else begin
            rgb_r  <= r_nxt;
            rgb_g  <= g_nxt;
            rgb_b  <= b_nxt;
            de_out <= de_s1;
        end
    end

endmodule
